// File: rtl/video_fetch_agen_if.sv
// video_fetch_agen_if: sync strobes, frame configuration and fetch request
// bundle between video sync, the address generator and the DRAM arbiter.
// The master side is the address generator; the slave side is its environment.
interface video_fetch_agen_if #(
    parameter int AW     = 21,
    parameter int PLANES = 2,
    parameter int XW     = 8,
    parameter int YW     = 9
);
    logic                 frame_start;
    logic                 line_start;
    logic                 vpix;
    logic                 video_next;
    logic [PLANES*AW-1:0] cfg_base;
    logic [XW-1:0]        cfg_words;
    logic [YW-1:0]        cfg_height;
    logic [15:0]          cfg_stride;
    logic [XW-1:0]        cfg_scroll_x;
    logic [YW-1:0]        cfg_scroll_y;
    logic [AW-1:0]        video_addr;
    logic                 addr_valid;
    logic [1:0]           plane;
    logic                 line_done;
    logic                 underrun;

    modport master (
        input  frame_start, line_start, vpix, video_next,
        input  cfg_base, cfg_words, cfg_height, cfg_stride, cfg_scroll_x, cfg_scroll_y,
        output video_addr, addr_valid, plane, line_done, underrun
    );

    modport slave (
        output frame_start, line_start, vpix, video_next,
        output cfg_base, cfg_words, cfg_height, cfg_stride, cfg_scroll_x, cfg_scroll_y,
        input  video_addr, addr_valid, plane, line_done, underrun
    );
endinterface

// File: rtl/video_fetch_agen.sv
// video_fetch_agen: linear framebuffer address generator for the video fetch
// path. Walks (cfg_words+1) horizontal positions x PLANES planes per visible
// line, with per-plane bases, line stride and X/Y start offsets.
// Optional feature macro: VIDEO_FETCH_AGEN_SCROLL_EN (hardware X/Y scroll).
// Without it every line starts at x=0 and every frame at y=0.
module video_fetch_agen #(
    parameter int AW     = 21,
    parameter int PLANES = 2,
    parameter int XW     = 8,
    parameter int YW     = 9
) (
    input  logic               clk,
    input  logic               rst,
    video_fetch_agen_if.master bus
);
    localparam int          PW      = YW + 16;
    localparam logic [1:0]  LAST_PL = 2'(PLANES - 1);

    typedef enum logic [1:0] {IDLE, FETCH, LINE_END} state_t;

    typedef struct packed {
        logic [XW-1:0] x;     // current horizontal word position
        logic [XW-1:0] cnt;   // positions fetched so far this line
        logic [YW-1:0] y;     // current line within the window
        logic [1:0]    pl;    // current plane
    } ctr_t;

    state_t          state, state_n;
    ctr_t            ctr, ctr_n;
    logic            underrun_q, underrun_n;
    logic [AW-1:0]   video_addr_q, addr_n;
    logic [AW-1:0]   line_off;
    logic [PW-1:0]   prod;

    // frame-stable copies of the configuration
    logic [3:0][AW-1:0] base_sh;
    logic [4*AW-1:0]    base_pad;
    logic [XW-1:0]      words_sh;
    logic [YW-1:0]      height_sh;
    logic [15:0]        stride_sh;
    logic [XW-1:0]      scroll_x_sh;
    logic [YW-1:0]      scroll_y_in;

    wire line_req = bus.line_start & bus.vpix;
    wire last_pl  = (ctr.pl == LAST_PL);

    // Pad the base table to four entries so a 2-bit plane index is always in range.
    generate
        if (PLANES < 4) begin : g_pad
            assign base_pad = {{((4 - PLANES) * AW){1'b0}}, bus.cfg_base};
        end else begin : g_nopad
            assign base_pad = bus.cfg_base;
        end
    endgenerate

`ifdef VIDEO_FETCH_AGEN_SCROLL_EN
    // Scroll X is held for the whole frame; scroll Y only seeds y at frame_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  scroll_x_sh <= '0;
        else if (bus.frame_start) scroll_x_sh <= bus.cfg_scroll_x;
    end
    assign scroll_y_in = bus.cfg_scroll_y;
`else
    assign scroll_x_sh = '0;
    assign scroll_y_in = '0;
    logic unused_scroll;
    assign unused_scroll = ^{bus.cfg_scroll_x, bus.cfg_scroll_y};
`endif

    // Shadow configuration: mid-frame writes only take effect at the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_sh   <= '0;
            words_sh  <= '0;
            height_sh <= '0;
            stride_sh <= '0;
        end else if (bus.frame_start) begin
            base_sh   <= base_pad;
            words_sh  <= bus.cfg_words;
            height_sh <= bus.cfg_height;
            stride_sh <= bus.cfg_stride;
        end
    end

    // Line offset is registered off the multiplier; sync leaves >=2 clocks
    // between any y update and the next line_start, so it is always settled.
    assign prod = PW'(ctr.y) * PW'(stride_sh);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) line_off <= '0;
        else     line_off <= AW'(prod);
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ctr        <= '0;
            underrun_q <= 1'b0;
        end else begin
            state      <= state_n;
            ctr        <= ctr_n;
            underrun_q <= underrun_n;
        end
    end

    // Next-state and counter update; frame_start overrides everything.
    always_comb begin
        state_n    = state;
        ctr_n      = ctr;
        underrun_n = underrun_q;
        if (bus.frame_start) begin
            state_n    = IDLE;
            underrun_n = 1'b0;
            ctr_n.y    = scroll_y_in;
            ctr_n.pl   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_req) begin
                        ctr_n.x   = scroll_x_sh;
                        ctr_n.cnt = '0;
                        ctr_n.pl  = '0;
                        state_n   = FETCH;
                    end
                end
                FETCH: begin
                    if (line_req) begin
                        // sync outran the fetch: drop this line, same y, restart
                        underrun_n = 1'b1;
                        ctr_n.x    = scroll_x_sh;
                        ctr_n.cnt  = '0;
                        ctr_n.pl   = '0;
                    end else if (bus.video_next) begin
                        if (!last_pl) begin
                            ctr_n.pl = ctr.pl + 2'd1;
                        end else begin
                            ctr_n.pl  = '0;
                            ctr_n.x   = (ctr.x == words_sh) ? '0 : ctr.x + XW'(1);
                            ctr_n.cnt = ctr.cnt + XW'(1);
                            if (ctr.cnt == words_sh) state_n = LINE_END;
                        end
                    end
                end
                LINE_END: begin
                    ctr_n.y = (ctr.y == height_sh) ? '0 : ctr.y + YW'(1);
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Address is built from next-cycle counters so it is registered with them.
    assign addr_n = base_sh[ctr_n.pl] + line_off + AW'(ctr_n.x);

    // Fetch address register, updated whenever the next state is fetching.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   video_addr_q <= '0;
        else if (state_n == FETCH) video_addr_q <= addr_n;
    end

    assign bus.video_addr = video_addr_q;
    assign bus.addr_valid = (state == FETCH);
    assign bus.line_done  = (state == LINE_END);
    assign bus.plane      = ctr.pl;
    assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_video_fetch_agen.sv
// tb_video_fetch_agen: scoreboard bench for video_fetch_agen. Expected
// addresses are queued by a line model when a line is started and popped by
// a monitor on every accepted fetch; scenario tasks check the control outputs.
module tb_video_fetch_agen;
    localparam int AW = 21, PLANES = 2, XW = 8, YW = 9;
`ifdef VIDEO_FETCH_AGEN_SCROLL_EN
    localparam bit SCROLL = 1'b1;
`else
    localparam bit SCROLL = 1'b0;
`endif

    typedef struct { logic [AW-1:0] a; logic [1:0] p; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0, errors = 0;
    exp_t q[$];
    exp_t mon_e;

    // model shadows
    logic [AW-1:0] m_base[PLANES];
    int m_words, m_height, m_stride, m_sx, my;

    video_fetch_agen_if #(.AW(AW), .PLANES(PLANES), .XW(XW), .YW(YW)) bus();
    video_fetch_agen #(.AW(AW), .PLANES(PLANES), .XW(XW), .YW(YW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // scoreboard monitor: every fetch the arbiter accepts must match the model
    always @(negedge clk) begin
        if (bus.addr_valid === 1'b1 && bus.video_next === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: got addr %h plane %0d, nothing expected", bus.video_addr, bus.plane);
            end else begin
                mon_e = q.pop_front();
                if (bus.video_addr !== mon_e.a || bus.plane !== mon_e.p) begin
                    errors++;
                    $display("FAIL sb_addr: got %h/p%0d want %h/p%0d", bus.video_addr, bus.plane, mon_e.a, mon_e.p);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_model();
        for (int p = 0; p < PLANES; p++) m_base[p] = bus.cfg_base[p*AW +: AW];
        m_words  = int'(bus.cfg_words);
        m_height = int'(bus.cfg_height);
        m_stride = int'(bus.cfg_stride);
        m_sx     = SCROLL ? int'(bus.cfg_scroll_x) : 0;
        my       = SCROLL ? int'(bus.cfg_scroll_y) : 0;
    endtask

    task automatic set_cfg(input logic [AW-1:0] b0, input logic [AW-1:0] b1, input int words,
                           input int height, input int stride, input int sx, input int sy);
        bus.cfg_base     = {b1, b0};
        bus.cfg_words    = XW'(words);
        bus.cfg_height   = YW'(height);
        bus.cfg_stride   = 16'(stride);
        bus.cfg_scroll_x = XW'(sx);
        bus.cfg_scroll_y = YW'(sy);
    endtask

    task automatic frame();
        bus.frame_start = 1'b1;
        bus.video_next  = 1'b0;
        tick();
        bus.frame_start = 1'b0;
        load_model();
        q.delete();
        tick();
    endtask

    // queue the expected fetches of one line for the current model y
    task automatic push_line();
        logic [AW-1:0] lo, a;
        int x;
        lo = AW'(my * m_stride);
        x  = m_sx;
        for (int k = 0; k <= m_words; k++) begin
            for (int p = 0; p < PLANES; p++) begin
                a = m_base[p] + lo + AW'(x);
                q.push_back('{a, 2'(p)});
            end
            x = (x == m_words) ? 0 : x + 1;
        end
    endtask

    task automatic start_line();
        push_line();
        bus.line_start = 1'b1;
        bus.vpix       = 1'b1;
        tick();
        bus.line_start = 1'b0;
        bus.vpix       = 1'b0;
    endtask

    // hold video_next until the request drops; cyc = accepted fetches (bounded)
    task automatic drain_line(output int cyc);
        bus.video_next = 1'b1;
        cyc = 0;
        while (bus.addr_valid === 1'b1 && cyc < 64) begin
            tick();
            cyc++;
        end
        bus.video_next = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks += 5;
        if (bus.video_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.video_addr); end
        if (bus.addr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.addr_valid); end
        if (bus.plane !== 2'd0) begin errors++; $display("FAIL reset_plane: got %0d want 0", bus.plane); end
        if (bus.line_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.line_done); end
        if (bus.underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", bus.underrun); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int cyc;
        set_cfg(21'h1000, 21'h8000, 3, 7, 'h50, 0, 0);
        frame();
        // acceptance strobes while idle must not start anything
        bus.video_next = 1'b1;
        tick();
        tick();
        bus.video_next = 1'b0;
        checks++;
        if (bus.addr_valid !== 1'b0) begin errors++; $display("FAIL idle_next: valid %b want 0", bus.addr_valid); end
        for (int l = 0; l < 2; l++) begin
            start_line();
            checks++;
            if (bus.addr_valid !== 1'b1) begin errors++; $display("FAIL basic_start: valid %b want 1", bus.addr_valid); end
            drain_line(cyc);
            checks += 3;
            if (cyc !== 8) begin errors++; $display("FAIL basic_len: got %0d fetches want 8", cyc); end
            if (bus.line_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", bus.line_done); end
            if (q.size() !== 0) begin errors++; $display("FAIL basic_left: %0d entries left want 0", q.size()); end
            tick();
            checks++;
            if (bus.line_done !== 1'b0) begin errors++; $display("FAIL basic_done_drop: got %b want 0", bus.line_done); end
            my = (my == m_height) ? 0 : my + 1;
            tick();
        end
    endtask

    task automatic test_scroll();
        int cyc;
        // with scroll disabled this run must look exactly like an unscrolled one
        set_cfg(21'h1000, 21'h8000, 3, 2, 'h50, 2, 1);
        frame();
        for (int l = 0; l < 4; l++) begin
            start_line();
            drain_line(cyc);
            checks += 2;
            if (cyc !== 8) begin errors++; $display("FAIL scroll_len: line %0d got %0d want 8", l, cyc); end
            if (bus.line_done !== 1'b1) begin errors++; $display("FAIL scroll_done: line %0d got %b", l, bus.line_done); end
            tick();
            my = (my == m_height) ? 0 : my + 1;
            tick();
        end
        set_cfg(21'h1000, 21'h8000, 3, 7, 'h50, 5, 3);
        frame();
        start_line();
        drain_line(cyc);
        checks++;
        if (cyc !== 8) begin errors++; $display("FAIL scroll2_len: got %0d want 8", cyc); end
        tick();
        my = (my == m_height) ? 0 : my + 1;
        tick();
    endtask

    task automatic test_underrun();
        int cyc;
        set_cfg(21'h0400, 21'h4000, 3, 7, 'h20, 0, 0);
        frame();
        start_line();
        bus.video_next = 1'b1;
        tick();
        tick();
        tick();
        bus.video_next = 1'b0;
        // sync asks for a new line with 5 fetches outstanding
        q.delete();
        start_line();
        checks += 3;
        if (bus.underrun !== 1'b1) begin errors++; $display("FAIL ur_set: got %b want 1", bus.underrun); end
        if (bus.addr_valid !== 1'b1) begin errors++; $display("FAIL ur_valid: got %b want 1", bus.addr_valid); end
        if (bus.plane !== 2'd0) begin errors++; $display("FAIL ur_plane: got %0d want 0", bus.plane); end
        drain_line(cyc);
        checks += 2;
        if (cyc !== 8) begin errors++; $display("FAIL ur_len: got %0d want 8", cyc); end
        if (bus.underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky: got %b want 1", bus.underrun); end
        tick();
        my = (my == m_height) ? 0 : my + 1;
        tick();
        // y must have advanced exactly once
        start_line();
        drain_line(cyc);
        checks++;
        if (cyc !== 8) begin errors++; $display("FAIL ur_next_len: got %0d want 8", cyc); end
        tick();
        tick();
        frame();
        checks++;
        if (bus.underrun !== 1'b0) begin errors++; $display("FAIL ur_clear: got %b want 0", bus.underrun); end
    endtask

    task automatic test_shadow();
        int cyc;
        set_cfg(21'h2000, 21'h9000, 3, 7, 'h40, 0, 0);
        frame();
        // mid-frame writes: the model keeps the old shadows
        set_cfg(21'h3000, 21'hA000, 1, 7, 'h10, 0, 0);
        start_line();
        drain_line(cyc);
        checks++;
        if (cyc !== 8) begin errors++; $display("FAIL shadow_old_len: got %0d want 8", cyc); end
        tick();
        tick();
        frame();
        start_line();
        drain_line(cyc);
        checks++;
        if (cyc !== 4) begin errors++; $display("FAIL shadow_new_len: got %0d want 4", cyc); end
        tick();
        my = (my == m_height) ? 0 : my + 1;
        tick();
        // frame_start in the middle of a fetch
        start_line();
        bus.video_next = 1'b1;
        tick();
        bus.video_next  = 1'b0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        checks += 2;
        if (bus.addr_valid !== 1'b0) begin errors++; $display("FAIL fs_abort: valid %b want 0", bus.addr_valid); end
        if (bus.line_done !== 1'b0) begin errors++; $display("FAIL fs_done: got %b want 0", bus.line_done); end
        load_model();
        q.delete();
        tick();
        start_line();
        drain_line(cyc);
        checks++;
        if (cyc !== 4) begin errors++; $display("FAIL fs_after_len: got %0d want 4", cyc); end
        tick();
        tick();
    endtask

    task automatic test_rst_mid();
        int cyc;
        set_cfg(21'h1234, 21'h5678, 3, 7, 'h50, 0, 0);
        frame();
        start_line();
        bus.video_next = 1'b1;
        tick();
        tick();
        tick();
        bus.video_next = 1'b0;
        rst = 1'b1;
        #1;
        checks += 4;
        if (bus.video_addr !== '0) begin errors++; $display("FAIL rst_addr: got %h want 0", bus.video_addr); end
        if (bus.addr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.addr_valid); end
        if (bus.plane !== 2'd0) begin errors++; $display("FAIL rst_plane: got %0d want 0", bus.plane); end
        if (bus.line_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus.line_done); end
        q.delete();
        tick();
        rst = 1'b0;
        tick();
        frame();
        start_line();
        drain_line(cyc);
        checks++;
        if (cyc !== 8) begin errors++; $display("FAIL rst_recover_len: got %0d want 8", cyc); end
        tick();
        tick();
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.line_start  = 1'b0;
        bus.vpix        = 1'b0;
        bus.video_next  = 1'b0;
        set_cfg('0, '0, 0, 0, 0, 0, 0);
        test_reset();
        test_basic();
        test_scroll();
        test_underrun();
        test_shadow();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
